pp_state_dump: RTL
==================

// Module: pp_state_dump
// PURPOSE
//  Debug readout engine for the 6-stage pipelined processor.
//  On a dump request it snapshots the architectural state: pc, the 8 GPRs and the cy/z flags.
//  It then streams the snapshot out as a framed sequence of 16-bit words over a valid/ready port.
//  It is the hardware reader that replaces hierarchical $display probing of pc/RF in benches and on FPGA.
// PARAMETERS
//  DATA_W  16  word width of pc, GPRs and output stream
//  NREG    8   number of GPRs captured (RF[0..NREG-1])
//  HDR_TAG 8'hA5  constant in header bits[15:8]
// PORTS
//  clk          in   1              processor clock, rising edge
//  rst_n        in   1              asynchronous active-low reset
//  dump_req     in   1              request pulse; sampled only in IDLE
//  pc_in        in   DATA_W         live program counter
//  rf_flat      in   NREG*DATA_W    live GPRs; RF[i] = rf_flat[DATA_W*i +: DATA_W]
//  cy_in        in   1              live carry flag
//  z_in         in   1              live zero flag
//  dout         out  DATA_W         stream data
//  dout_valid   out  1              stream valid
//  dout_ready   in   1              stream ready from sink
//  dout_last    out  1              high with the final word of a frame
//  dump_busy    out  1              high from request acceptance to final handshake
//  dump_overrun out  1              sticky: a request arrived while busy
//  dump_cnt     out  16             count of completed frames
// BEHAVIOUR
//  Reset: every output is 0, FSM is IDLE, and the snapshot regs are 0.
//  Reset is asynchronous: valid drops immediately with no partial last.
//  FSM has two states, IDLE and SEND.
//   IDLE -> SEND on the edge that samples dump_req=1.
//     The same edge captures pc_in, rf_flat, cy_in and z_in into shadow regs, sets idx=0 and dump_busy=1, and clears dump_overrun.
//     dout_valid is high in the cycle after that edge (1-cycle latency).
//   SEND: dout = frame[idx] and dout_valid = 1.
//     On valid&&ready: if idx == LAST, go to IDLE, drop dump_busy and increment dump_cnt; otherwise increment idx.
//  Frame layout:
//   w0 = {HDR_TAG, 6'b0, cy, z}
//   w1 = pc
//   w2..w(NREG+1) = RF[0]..RF[NREG-1]
//   LAST = NREG+1 (10 words at defaults)
//  Handshake rules:
//   dout and dout_last are held stable while valid && !ready.
//   valid never drops mid-frame and never depends on ready.
//   Back-to-back frames carry one IDLE cycle between them.
//  The shadow regs isolate the frame: live input changes after capture never alter it.
//  dump_req=1 in SEND is ignored (no queueing) and sets dump_overrun.
//  dump_req held high in IDLE starts a new frame each time IDLE is re-entered.
//  dump_cnt wraps 16'hFFFF -> 16'h0000.
// CONFIGURATION
//  Macro PP_DUMP_CHECKSUM_EN.
//  Defined: the frame gains a trailing word, LAST = NREG+2 (11 words).
//   That word is the XOR of all preceding frame words and carries dout_last.
//  Undefined: there is no checksum word and no checksum logic; LAST = NREG+1.
// TESTING
//  T1 reset:
//   Assert rst_n=0 mid-cycle -> dout/valid/last/busy/overrun/cnt are all 0 immediately.
//  T2 basic frame:
//   Stimulus: RF[i]=i+1, pc=3, cy=1, z=0, ready=1, 1-cycle req.
//   Response: A502, 0003, 0001..0008 on consecutive cycles; last on 0008; cnt=1; busy low after.
//  T3 backpressure:
//   Same inputs as T2, with ready toggling 1,0,1,0...
//   Response: identical 10 words, each held during stalls; exactly 10 handshakes.
//  T4 isolation/overrun:
//   After req, change rf_flat to FFFF and pulse req at word 3.
//   Response: frame still carries 0001..0008; overrun=1; cnt increments once.
//  T5 reset mid-frame:
//   rst_n=0 during word 4 -> valid=0 at once.
//   After release, a new req yields a fresh frame starting at A502; cnt=1.
//  T6 checksum (PP_DUMP_CHECKSUM_EN):
//   T2 stimulus -> 11th word A509 with last; 0008 carries no last.

Source files
------------

// File: rtl/pp_state_dump.sv
// pp_state_dump: snapshots pc, GPRs and cy/z on request and streams them as a framed word sequence.
// Defining PP_DUMP_CHECKSUM_EN appends a trailing XOR checksum word to every frame.
module pp_state_dump #(
    parameter int         DATA_W  = 16,
    parameter int         NREG    = 8,
    parameter logic [7:0] HDR_TAG = 8'hA5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_dump_req,
    input  logic [DATA_W-1:0]      i_pc,
    input  logic [NREG*DATA_W-1:0] i_rf_flat,
    input  logic                   i_cy,
    input  logic                   i_z,
    output logic [DATA_W-1:0]      o_dout,
    output logic                   o_dout_valid,
    input  logic                   i_dout_ready,
    output logic                   o_dout_last,
    output logic                   o_dump_busy,
    output logic                   o_dump_overrun,
    output logic [15:0]            o_dump_cnt
);

`ifdef PP_DUMP_CHECKSUM_EN
    localparam int LAST = NREG + 2;
`else
    localparam int LAST = NREG + 1;
`endif
    localparam int               IDX_W    = $clog2(LAST + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LAST);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_pc;
    logic [DATA_W-1:0] r_rf [NREG];
    logic              r_cy;
    logic              r_z;
    logic              r_overrun;
    logic [15:0]       r_cnt;

    logic              w_accept;
    logic              w_fire;
    logic              w_final;
    logic [DATA_W-1:0] w_hdr;
    logic [DATA_W-1:0] w_word;

    assign w_accept = (r_state == IDLE) && i_dump_req;
    assign w_fire   = (r_state == SEND) && i_dout_ready;
    assign w_final  = w_fire && (r_idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = SEND;
                end
            end
            SEND: begin
                if (w_final) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Shadow copy of the architectural state; only refreshed when a request is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= '0;
            r_cy <= 1'b0;
            r_z  <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                r_rf[i] <= '0;
            end
        end else if (w_accept) begin
            r_pc <= i_pc;
            r_cy <= i_cy;
            r_z  <= i_z;
            for (int i = 0; i < NREG; i++) begin
                r_rf[i] <= i_rf_flat[DATA_W*i +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
        end else if (w_accept) begin
            r_idx <= '0;
        end else if (w_fire && !w_final) begin
            r_idx <= r_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
            r_cnt     <= '0;
        end else begin
            if (w_accept) begin
                r_overrun <= 1'b0;
            end else if ((r_state == SEND) && i_dump_req) begin
                r_overrun <= 1'b1;
            end
            if (w_final) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    assign w_hdr = {HDR_TAG, {(DATA_W-10){1'b0}}, r_cy, r_z};

`ifdef PP_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] w_csum;

    always_comb begin
        w_csum = w_hdr ^ r_pc;
        for (int i = 0; i < NREG; i++) begin
            w_csum = w_csum ^ r_rf[i];
        end
    end
`endif

    // Word select: header, pc, then GPRs in index order (checksum last when enabled).
    always_comb begin
        w_word = '0;
        if (r_idx == IDX_W'(0)) begin
            w_word = w_hdr;
        end else if (r_idx == IDX_W'(1)) begin
            w_word = r_pc;
        end
`ifdef PP_DUMP_CHECKSUM_EN
        else if (r_idx == LAST_IDX) begin
            w_word = w_csum;
        end
`endif
        for (int i = 0; i < NREG; i++) begin
            if (r_idx == IDX_W'(i + 2)) begin
                w_word = r_rf[i];
            end
        end
    end

    assign o_dout_valid   = (r_state == SEND);
    assign o_dout         = (r_state == SEND) ? w_word : '0;
    assign o_dout_last    = (r_state == SEND) && (r_idx == LAST_IDX);
    assign o_dump_busy    = (r_state == SEND);
    assign o_dump_overrun = r_overrun;
    assign o_dump_cnt     = r_cnt;

endmodule
